// File: rtl/scan_pkg.sv
// Shared state encoding and defaults for the scan_sel4 channel scanner.
// Defining SCAN_BLANK_EN adds the per-slot BLANK state.
package scan_pkg;

   localparam int unsigned DivDefault   = 50000;
   localparam int unsigned BlankDefault = 4;
   localparam int unsigned MaxWidth     = 64;
   localparam logic [MaxWidth-1:0] AllOnes = '1;

`ifdef SCAN_BLANK_EN
   typedef enum logic [1:0] {StIdle, StShow, StBlank} scan_state_e;
`else
   typedef enum logic [1:0] {StIdle, StShow} scan_state_e;
`endif

   function automatic int unsigned cnt_width(input int unsigned div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/scan_tick.sv
// Slot prescaler for scan_sel4: counts 0..DIV-1 while running and pulses tc_o on the
// terminal count. Held at zero by rst or while not running.
module scan_tick
   import scan_pkg::*;
#(
   parameter int unsigned DIV  = DivDefault,
   parameter int unsigned CntW = cnt_width(DIV)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run_i,
   output logic [CntW-1:0] cnt_o,
   output logic            tc_o
);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tc_o  = run_i && (cnt_q == CntW'(DIV - 1));
   assign cnt_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (!run_i || tc_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/scan_sel4.sv
// Four-channel time-multiplexed scanner with double-buffered channel words.
// Optional SCAN_BLANK_EN blanks the first BLANK cycles of every channel slot.
module scan_sel4
   import scan_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV   = DivDefault,
   parameter int unsigned BLANK = BlankDefault
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               load_valid,
   output logic               load_ready,
   input  logic [4*WIDTH-1:0] load_data,
   output logic [WIDTH-1:0]   D,
   output logic               s1,
   output logic               s0,
   output logic               frame_done
);

   localparam int unsigned CntW = cnt_width(DIV);
   localparam logic [WIDTH-1:0] BlankWord = AllOnes[WIDTH-1:0];

`ifdef SCAN_BLANK_EN
   localparam scan_state_e SlotStart = (BLANK > 0) ? StBlank : StShow;
`else
   localparam scan_state_e SlotStart = StShow;
`endif

   scan_state_e        state_q, state_d;
   logic [1:0]         chan_q, chan_d;
   logic [4*WIDTH-1:0] active_q, active_d;
   logic [4*WIDTH-1:0] pending_q, pending_d;
   logic               pending_full_q, pending_full_d;
   logic [WIDTH-1:0]   d_q, d_d;
   logic [1:0]         sel_q, sel_d;
   logic               frame_done_q, frame_done_d;
   logic [CntW-1:0]    cnt;
   logic               tick;
   logic               run;
   logic               accept;
   logic               wrap;

   assign run = enable && (state_q != StIdle);

   scan_tick #(
      .DIV  (DIV),
      .CntW (CntW)
   ) u_tick (
      .clk   (clk),
      .rst   (rst),
      .run_i (run),
      .cnt_o (cnt),
      .tc_o  (tick)
   );

`ifndef SCAN_BLANK_EN
   logic unused_cfg;
   assign unused_cfg = ^{cnt, BLANK};
`endif

   always_comb begin
      state_d        = state_q;
      chan_d         = chan_q;
      active_d       = active_q;
      pending_d      = pending_q;
      pending_full_d = pending_full_q;
      frame_done_d   = 1'b0;
      wrap           = 1'b0;
      accept         = load_valid && !pending_full_q;

      if (!enable) begin
         state_d = StIdle;
         chan_d  = 2'd0;
      end else if (state_q == StIdle) begin
         state_d = SlotStart;
      end else if (tick) begin
         state_d = SlotStart;
         chan_d  = chan_q + 2'd1;
         wrap    = (chan_q == 2'd3);
`ifdef SCAN_BLANK_EN
      end else if (state_q == StBlank && cnt == CntW'(BLANK - 1)) begin
         state_d = StShow;
`endif
      end

      // A load taken in the wrap cycle only stages; active changes at the next wrap.
      if (accept) begin
         pending_d      = load_data;
         pending_full_d = 1'b1;
      end
      if (wrap) begin
         frame_done_d = 1'b1;
         if (pending_full_q) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
         end
      end

      // Outputs are registered, so derive them from the next state.
      sel_d = chan_d;
      d_d   = active_d[32'(chan_d) * WIDTH +: WIDTH];
      if (state_d != StShow) begin
         d_d = BlankWord;
      end
      if (state_d == StIdle) begin
         sel_d = 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         chan_q         <= 2'd0;
         active_q       <= '1;
         pending_q      <= '1;
         pending_full_q <= 1'b0;
         d_q            <= BlankWord;
         sel_q          <= 2'd0;
         frame_done_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         chan_q         <= chan_d;
         active_q       <= active_d;
         pending_q      <= pending_d;
         pending_full_q <= pending_full_d;
         d_q            <= d_d;
         sel_q          <= sel_d;
         frame_done_q   <= frame_done_d;
      end
   end

   assign load_ready = !pending_full_q;
   assign D          = d_q;
   assign s1         = sel_q[1];
   assign s0         = sel_q[0];
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_sel4.sv
// Scoreboard bench for scan_sel4: stimulus queues per-cycle expectations, a negedge
// monitor pops and compares. Build with SCAN_BLANK_EN for the blanking variant.
module tb_scan_sel4;

`ifdef SCAN_BLANK_EN
   localparam int TbDiv   = 6;
   localparam int TbBlank = 2;
`else
   localparam int TbDiv   = 4;
   localparam int TbBlank = 0;
`endif
   localparam int FrameLen = 4 * TbDiv;

   typedef struct {
      int         cyc;
      logic [7:0] d;
      logic [1:0] sel;
      logic       fd;
      logic       rdy;
      string      nm;
      int         idx;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] load_data;
   logic [7:0]  D;
   logic        s1;
   logic        s0;
   logic        frame_done;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   scan_sel4 #(
      .WIDTH (8),
      .DIV   (TbDiv),
      .BLANK (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .D          (D),
      .s1         (s1),
      .s0         (s0),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         mon_e = exp_q.pop_front();
         checks++;
         if (mon_e.cyc != cyc || D !== mon_e.d || {s1, s0} !== mon_e.sel ||
             frame_done !== mon_e.fd || load_ready !== mon_e.rdy) begin
            errors++;
            $display("FAIL %s[%0d] cyc %0d: got D=%h sel=%0d fd=%b rdy=%b, expected D=%h sel=%0d fd=%b rdy=%b (due cyc %0d)",
                     mon_e.nm, mon_e.idx, cyc, D, {s1, s0}, frame_done, load_ready,
                     mon_e.d, mon_e.sel, mon_e.fd, mon_e.rdy, mon_e.cyc);
         end
      end
   end

   // Drive inputs for one edge and queue the outputs expected right after it.
   task automatic step(input logic r, input logic en, input logic lv, input logic [31:0] ld,
                       input logic [7:0] ed, input logic [1:0] es, input logic efd,
                       input logic erdy, input string nm, input int idx);
      exp_t e;
      rst        = r;
      enable     = en;
      load_valid = lv;
      load_data  = ld;
      e.cyc = cyc + 1;
      e.d   = ed;
      e.sel = es;
      e.fd  = efd;
      e.rdy = erdy;
      e.nm  = nm;
      e.idx = idx;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // n enabled cycles starting at a slot boundary; optional loads at steps la / lb,
   // acc is the step whose load is accepted (load_ready low from then on).
   task automatic frame(input logic [31:0] words, input logic fd0, input logic rdy0, input int n,
                        input int la, input logic [31:0] da, input int lb,
                        input logic [31:0] db, input int acc, input string nm);
      for (int i = 0; i < n; i++) begin
         int          ch;
         logic [7:0]  ed;
         logic        erdy;
         logic        lv;
         logic [31:0] ld;
         ch   = (i / TbDiv) % 4;
         ed   = words[ch*8 +: 8];
         if ((i % TbDiv) < TbBlank) ed = 8'hFF;
         erdy = (acc >= 0 && i >= acc) ? 1'b0 : rdy0;
         lv   = (i == la) || (i == lb);
         ld   = (i == lb) ? db : da;
         step(1'b0, 1'b1, lv, ld, ed, 2'(ch), (i == 0) ? fd0 : 1'b0, erdy, nm, i);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      enable     = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;

      step(1'b1, 1'b0, 1'b0, 32'h0, 8'hFF, 2'd0, 1'b0, 1'b1, "reset", 0);
      step(1'b1, 1'b1, 1'b1, 32'h12345678, 8'hFF, 2'd0, 1'b0, 1'b1, "reset_override", 0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 8'hFF, 2'd0, 1'b0, 1'b1, "idle", 0);
      step(1'b0, 1'b0, 1'b1, 32'h44332211, 8'hFF, 2'd0, 1'b0, 1'b0, "load_idle", 0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 8'hFF, 2'd0, 1'b0, 1'b0, "idle_full", 0);

      frame(32'hFFFFFFFF, 1'b0, 1'b0, FrameLen, -1, 32'h0, -1, 32'h0, -1, "first_frame");
      frame(32'h44332211, 1'b1, 1'b1, FrameLen, -1, 32'h0, -1, 32'h0, -1, "loaded_frame");
      frame(32'h44332211, 1'b1, 1'b1, FrameLen, 2, 32'hA4A3A2A1, 6, 32'hB4B3B2B1, 2,
            "stage_while_full");
      frame(32'hA4A3A2A1, 1'b1, 1'b1, FrameLen, -1, 32'h0, -1, 32'h0, -1, "first_staged_shown");
      frame(32'hA4A3A2A1, 1'b1, 1'b1, FrameLen, 0, 32'hC4C3C2C1, -1, 32'h0, 0, "wrap_load");
      frame(32'hC4C3C2C1, 1'b1, 1'b1, FrameLen, 1, 32'hD4D3D2D1, -1, 32'h0, 1, "fd_cycle_load");
      frame(32'hD4D3D2D1, 1'b1, 1'b1, FrameLen, -1, 32'h0, -1, 32'h0, -1, "fd_load_shown");

      frame(32'hD4D3D2D1, 1'b1, 1'b1, 2 * TbDiv + 1, -1, 32'h0, -1, 32'h0, -1, "to_ch2");
      step(1'b0, 1'b0, 1'b0, 32'h0, 8'hFF, 2'd0, 1'b0, 1'b1, "disable", 0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 8'hFF, 2'd0, 1'b0, 1'b1, "disable_hold", 0);
      frame(32'hD4D3D2D1, 1'b0, 1'b1, TbDiv + 2, 2, 32'hE4E3E2E1, -1, 32'h0, 2, "reenable");

      step(1'b1, 1'b1, 1'b1, 32'hF4F3F2F1, 8'hFF, 2'd0, 1'b0, 1'b1, "reset_mid_frame", 0);
      frame(32'hFFFFFFFF, 1'b0, 1'b1, FrameLen, -1, 32'h0, -1, 32'h0, -1, "after_reset");
      frame(32'hFFFFFFFF, 1'b1, 1'b1, TbDiv, -1, 32'h0, -1, 32'h0, -1, "staged_lost");

      enable = 1'b0;
      repeat (3) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/scan_sel4.md
SCAN_SEL4 -- requirements
Module: scan_sel4

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per channel word.
REQ-002 SHALL have parameter DIV, default 50000, meaning clk cycles per channel slot (>=2).
REQ-003 SHALL have parameter BLANK, default 4, meaning blank cycles per slot when SCAN_BLANK_EN is defined (< DIV).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port enable, input, 1, scan run (1) / idle (0).
REQ-008 SHALL have port load_valid, input, 1, load_data is offered.
REQ-009 SHALL have port load_ready, output, 1, pending buffer is free.
REQ-010 SHALL have port load_data, input, 4*WIDTH, channel words; ch0 in [WIDTH-1:0], ch3 in MSBs.
REQ-011 SHALL have port D, output, WIDTH, selected word to the downstream 1:4 demux.
REQ-012 SHALL have ports s1 and s0, output, 1 each, channel select {s1,s0}.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse on channel wrap 3->0.

Function
REQ-014 SHALL hold two banks: active (displayed) and pending (staged), plus pending_full flag.
REQ-015 SHALL drive load_ready = !pending_full; a load is accepted when load_valid && load_ready on a rising edge, which writes pending and sets pending_full.
REQ-016 SHALL use states IDLE, SHOW and, with the macro only, BLANK; all outputs are registered.
REQ-017 SHALL, in IDLE: D = all ones, {s1,s0} = 00, prescaler = 0, channel = 0; IDLE->SHOW when enable=1, and D = active[0] on the next cycle.
REQ-018 SHALL, in SHOW: count the prescaler 0..DIV-1; at DIV-1 it advances the channel mod 4 and restarts the prescaler at 0.
REQ-019 SHALL drive D = active[channel] and {s1,s0} = channel while in SHOW.
REQ-020 SHALL, on the 3->0 advance, pulse frame_done for exactly one cycle and, if pending_full, copy pending to active and clear pending_full in that same cycle.
REQ-021 SHALL, for a load accepted in the wrap cycle while pending was empty, stage the word for the next wrap, with no bypass to active.
REQ-022 SHALL, on enable=0 in any state, go to IDLE on the next edge; active, pending and pending_full are retained.
REQ-023 SHALL keep load_ready and acceptance independent of enable.

Reset
REQ-024 SHALL, on rst=1 at a clock edge: state=IDLE, active and pending = all ones, pending_full=0, D = all ones, {s1,s0}=00, frame_done=0, load_ready=1 on the following cycle.
REQ-025 SHALL let rst override enable and load_valid in the same cycle; reset mid-frame discards pending.

Configuration
REQ-026 SHALL, with SCAN_BLANK_EN defined, spend the first BLANK cycles of each slot in BLANK with D = all ones and {s1,s0} = new channel, then SHOW for the remaining DIV-BLANK cycles.
REQ-027 SHALL, without SCAN_BLANK_EN, omit the BLANK state entirely; the slot is DIV SHOW cycles.

Structure
REQ-028 SHALL place state encoding, DIV/BLANK defaults and the all-ones blank constant in shared package scan_pkg.
REQ-029 SHALL implement the prescaler as sub-module scan_tick, emitting a terminal-count pulse and cleared by rst or IDLE.

Verification
REQ-030 SHALL cover: DIV=4, no macro, load 0x44332211, enable=1 -> D=FF until the first wrap, then 11,22,33,44 for 4 cycles each; frame_done pulses once per 16 cycles.
REQ-031 SHALL cover: a second load mid-frame while pending is full -> load_ready=0, the word is not accepted, and the first staged word is shown after the wrap.
REQ-032 SHALL cover: load asserted exactly in the frame_done cycle with pending empty -> the new word appears one frame later, not immediately.
REQ-033 SHALL cover: enable dropped while channel=2 -> next cycle D=FF, {s1,s0}=00; re-enable -> D=active[0] one cycle later.
REQ-034 SHALL cover: rst asserted mid-frame with pending_full=1 -> D=FF, load_ready=1, staged data lost.
REQ-035 SHALL cover: SCAN_BLANK_EN, DIV=6, BLANK=2 -> each slot shows 2 cycles of FF with the new select, then 4 cycles of data.
